server_rx_checker: RTL

Receive-side endpoint for the test-traffic generator running on each server port. It sits on the port's RX AXI-Stream, parses each fixed-length test frame, validates its header, length and error flag, and computes one-way latency from the embedded timestamp. It reports per-packet results and running good/error packet counters to the statistics logic.

---
 rtl/server_rx_checker.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/server_rx_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// server_rx_checker
//
// Receive-side endpoint for the per-port test-traffic generator. It parses each
// fixed-length test frame arriving on the RX AXI-Stream and validates three
// things: the header (destination MAC and EtherType), the length/keep, and the
// tuser error flag. It also computes one-way latency from the timestamp carried
// in the first payload beat. Per-frame results and saturating good/error frame
// counters go to the statistics logic.
//
// Optional feature (macro SERVER_RX_MINMAX_EN):
//   When defined, the block adds o_lat_min/o_lat_max, which track the minimum
//   and maximum latency over good frames. When undefined, these ports and their
//   registers are absent.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_stat_rx_status      link up; low aborts the frame in progress
//   i_time_stamp          free-running local time (same timebase as the TX side)
//   rx_axis_*             AXI-Stream RX (tvalid/tdata/tlast/tkeep/tuser, tready)
//   o_pkt_done            one-cycle pulse per completed frame
//   o_pkt_ok              frame passed all checks (valid with o_pkt_done)
//   o_err_flags           [0] dst MAC, [1] EtherType, [2] length/keep,
//                         [3] tuser at tlast (valid with o_pkt_done)
//   o_src_mac             source MAC of the frame (valid with o_pkt_done)
//   o_latency             local time at tlast minus the embedded TX timestamp
//   o_good_cnt/o_err_cnt  saturating frame counters
//   o_lat_min/o_lat_max   (SERVER_RX_MINMAX_EN only) latency extremes of good frames
//   o_dbg_state           current FSM state (0 IDLE, 1 HDR1, 2 PAYLOAD, 3 DONE)
//
// Handshake: a beat is transferred in any cycle where rx_axis_tvalid and
// rx_axis_tready are both 1. Cycles with tvalid low are idle and are ignored.
// tready is 1 in every cycle outside reset, so the checker never back-pressures.
// -----------------------------------------------------------------------------
module server_rx_checker #(
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
  parameter int          P_PKT_LEN     = 128,
  parameter logic [15:0] P_ETH_TYPE    = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stat_rx_status,
  input  logic [63:0] i_time_stamp,
  input  logic        rx_axis_tvalid,
  input  logic [63:0] rx_axis_tdata,
  input  logic        rx_axis_tlast,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tuser,
  output logic        rx_axis_tready,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [3:0]  o_err_flags,
  output logic [47:0] o_src_mac,
  output logic [63:0] o_latency,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_err_cnt,
`ifdef SERVER_RX_MINMAX_EN
  output logic [63:0] o_lat_min,
  output logic [63:0] o_lat_max,
`endif
  output logic [1:0]  o_dbg_state
);

  localparam logic [15:0] LEN_M1 = 16'(P_PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR1    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        tready_q;

  // Per-frame accumulators
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        dst_err_q, dst_err_d;
  logic        type_err_q, type_err_d;
  logic        len_err_q, len_err_d;
  logic [47:0] src_acc_q, src_acc_d;
  logic [63:0] tx_ts_q, tx_ts_d;

  // Registered results
  logic        pkt_ok_q, pkt_ok_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [63:0] latency_q, latency_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
`ifdef SERVER_RX_MINMAX_EN
  logic [63:0] lat_min_q, lat_min_d;
  logic [63:0] lat_max_q, lat_max_d;
`endif

  logic        beat;
  logic        accept;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] beat_idx;
  logic [3:0]  flags_now;
  logic [63:0] lat_now;

  assign beat        = rx_axis_tvalid & tready_q;
  // Beats are only meaningful while the link is up; a beat during link-down is dropped.
  assign accept      = beat & i_stat_rx_status;
  // A beat in IDLE or DONE is beat 0 of a new frame (DONE allows back-to-back frames).
  assign frame_start = accept & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign frame_end   = accept & rx_axis_tlast;
  assign beat_idx    = frame_start ? 16'd0 : beat_cnt_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = rx_axis_tlast ? S_DONE : S_HDR1;
      end
      S_HDR1: begin
        if (accept) state_d = rx_axis_tlast ? S_DONE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Overlong frames stay here, discarding beats until tlast.
        if (accept && rx_axis_tlast) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (accept) state_d = rx_axis_tlast ? S_DONE : S_HDR1;
      end
      default: state_d = S_IDLE;
    endcase
    // Link-down abandons any partial frame. DONE has already committed its
    // results, so leaving it early loses nothing.
    if (!i_stat_rx_status) state_d = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_pkt_done  = (state_q == S_DONE);
    o_dbg_state = state_q;
  end

  // ---------------------------------------------------------------------------
  // Frame accumulation
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    dst_err_d  = dst_err_q;
    type_err_d = type_err_q;
    len_err_d  = len_err_q;
    src_acc_d  = src_acc_q;
    tx_ts_d    = tx_ts_q;
    // Fields not yet received read as 0, so a new frame starts from a clean slate.
    if (frame_start) begin
      dst_err_d  = 1'b0;
      type_err_d = 1'b0;
      len_err_d  = 1'b0;
      src_acc_d  = '0;
      tx_ts_d    = '0;
    end
    if (accept) begin
      beat_cnt_d = (beat_idx == 16'hFFFF) ? beat_idx : beat_idx + 16'd1;
      if (rx_axis_tkeep != 8'hFF) len_err_d = 1'b1;
      // tlast must land exactly on the final beat. A non-tlast beat at or beyond
      // the final index means the frame is overlong.
      if (rx_axis_tlast ? (beat_idx != LEN_M1) : (beat_idx >= LEN_M1)) len_err_d = 1'b1;
      case (beat_idx)
        16'd0: begin
          dst_err_d          = (rx_axis_tdata[63:16] != P_MY_PORT_MAC);
          src_acc_d[47:32]   = rx_axis_tdata[15:0];
        end
        16'd1: begin
          src_acc_d[31:0]    = rx_axis_tdata[63:32];
          type_err_d         = (rx_axis_tdata[31:16] != P_ETH_TYPE);
        end
        16'd2: begin
          tx_ts_d            = rx_axis_tdata;
        end
        default: ;
      endcase
    end
  end

  assign flags_now = {rx_axis_tuser, len_err_d, type_err_d, dst_err_d};
  // Frames shorter than 3 beats carry no timestamp and report zero latency.
  assign lat_now   = (beat_idx >= 16'd2) ? (i_time_stamp - tx_ts_d) : 64'd0;

  // ---------------------------------------------------------------------------
  // Results and counters: committed on the tlast edge so that they are visible
  // together with the o_pkt_done pulse in DONE.
  // ---------------------------------------------------------------------------
  always_comb begin
    pkt_ok_d    = pkt_ok_q;
    err_flags_d = err_flags_q;
    src_mac_d   = src_mac_q;
    latency_d   = latency_q;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
`ifdef SERVER_RX_MINMAX_EN
    lat_min_d   = lat_min_q;
    lat_max_d   = lat_max_q;
`endif
    if (frame_end) begin
      pkt_ok_d    = (flags_now == 4'd0);
      err_flags_d = flags_now;
      src_mac_d   = src_acc_d;
      latency_d   = lat_now;
      if (flags_now == 4'd0) begin
        if (good_cnt_q != 32'hFFFF_FFFF) good_cnt_d = good_cnt_q + 32'd1;
`ifdef SERVER_RX_MINMAX_EN
        if (lat_now < lat_min_q) lat_min_d = lat_now;
        if (lat_now > lat_max_q) lat_max_d = lat_now;
`endif
      end else begin
        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_d = err_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tready_q    <= 1'b0;
      beat_cnt_q  <= '0;
      dst_err_q   <= 1'b0;
      type_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      src_acc_q   <= '0;
      tx_ts_q     <= '0;
      pkt_ok_q    <= 1'b0;
      err_flags_q <= '0;
      src_mac_q   <= '0;
      latency_q   <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
`ifdef SERVER_RX_MINMAX_EN
      lat_min_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      lat_max_q   <= '0;
`endif
    end else begin
      tready_q    <= 1'b1;
      beat_cnt_q  <= beat_cnt_d;
      dst_err_q   <= dst_err_d;
      type_err_q  <= type_err_d;
      len_err_q   <= len_err_d;
      src_acc_q   <= src_acc_d;
      tx_ts_q     <= tx_ts_d;
      pkt_ok_q    <= pkt_ok_d;
      err_flags_q <= err_flags_d;
      src_mac_q   <= src_mac_d;
      latency_q   <= latency_d;
      good_cnt_q  <= good_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef SERVER_RX_MINMAX_EN
      lat_min_q   <= lat_min_d;
      lat_max_q   <= lat_max_d;
`endif
    end
  end

  assign rx_axis_tready = tready_q;
  assign o_pkt_ok       = pkt_ok_q;
  assign o_err_flags    = err_flags_q;
  assign o_src_mac      = src_mac_q;
  assign o_latency      = latency_q;
  assign o_good_cnt     = good_cnt_q;
  assign o_err_cnt      = err_cnt_q;
`ifdef SERVER_RX_MINMAX_EN
  assign o_lat_min      = lat_min_q;
  assign o_lat_max      = lat_max_q;
`endif

endmodule
